// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and constants for the pipeline boundary registers (package pipe_pkg).
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_HOLD   = 2'd1,
      ST_BUBBLE = 2'd2,
      ST_FLUSH  = 2'd3
   } stage_state_e;

   localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;

   // MIPS CP0 ExcCode values; 0 doubles as "no exception" in the pipeline
   localparam logic [4:0] EXC_NONE = 5'd0;
   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter with synchronous clear; only built when PIPE_STAGE_PERF_EN is defined.
`ifdef PIPE_STAGE_PERF_EN
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule
`endif

// File: rtl/pipe_stage_reg.sv
// Generic pipeline boundary register with hold, bubble, flush and exception merging.
// Optional perf counters (bubble/flush) are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int                   DATA_W         = 128,
   parameter int                   PC_W           = 32,
   parameter int                   EXC_W          = 5,
   parameter logic [PC_W-1:0]      RESET_PC       = '0,
   parameter logic [PC_W-1:0]      HANDLER_PC     = PC_W'(HANDLER_PC_DEFAULT),
   parameter int                   BUBBLE_KEEP_PC = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              stall,
   input  logic              req,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [PC_W-1:0]   pc_i,
   input  logic [EXC_W-1:0]  exc_i,
   input  logic [EXC_W-1:0]  exc_new_i,
   input  logic              bd_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic [PC_W-1:0]   pc_o,
   output logic [EXC_W-1:0]  exc_o,
   output logic              bd_o,
   output logic [1:0]        state_o
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [15:0]       bubble_cnt_o,
   output logic [15:0]       flush_cnt_o
`endif
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [EXC_W-1:0]  exc_q, exc_d;
   logic              bd_q, bd_d;
   stage_state_e      state_q, state_d;

   // Flush beats bubble beats advance; anything else holds. Older exception wins the merge.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      pc_d    = pc_q;
      exc_d   = exc_q;
      bd_d    = bd_q;
      state_d = ST_HOLD;
      if (req) begin
         valid_d = 1'b0;
         data_d  = '0;
         pc_d    = HANDLER_PC;
         exc_d   = '0;
         bd_d    = 1'b0;
         state_d = ST_FLUSH;
      end else if (stall) begin
         valid_d = 1'b0;
         data_d  = '0;
         exc_d   = '0;
         pc_d    = (BUBBLE_KEEP_PC != 0) ? pc_i : '0;
         bd_d    = (BUBBLE_KEEP_PC != 0) ? bd_i : 1'b0;
         state_d = ST_BUBBLE;
      end else if (en) begin
         valid_d = valid_i;
         data_d  = data_i;
         pc_d    = pc_i;
         bd_d    = bd_i;
         exc_d   = !valid_i         ? '0
                 : (exc_i != '0)    ? exc_i
                 :                    exc_new_i;
         state_d = ST_RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         pc_q    <= RESET_PC;
         exc_q   <= '0;
         bd_q    <= 1'b0;
         state_q <= ST_RUN;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         pc_q    <= pc_d;
         exc_q   <= exc_d;
         bd_q    <= bd_d;
         state_q <= state_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign pc_o    = pc_q;
   assign exc_o   = exc_q;
   assign bd_o    = bd_q;
   assign state_o = state_q;

`ifdef PIPE_STAGE_PERF_EN
   logic bubble_evt;
   logic flush_evt;

   assign bubble_evt = (state_d == ST_BUBBLE);
   assign flush_evt  = (state_d == ST_FLUSH);

   sat_counter #(.W(16)) u_bubble_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc_i   (bubble_evt),
      .count_o (bubble_cnt_o)
   );

   sat_counter #(.W(16)) u_flush_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc_i   (flush_evt),
      .count_o (flush_cnt_o)
   );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one DUT keeps PC on bubbles, a second zeroes it.
// Perf counter checks are compiled in when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;
   import pipe_pkg::*;

   logic         clk = 1'b0;
   logic         reset, en, stall, req, valid_i, bd_i;
   logic [127:0] data_i;
   logic [31:0]  pc_i;
   logic [4:0]   exc_i, exc_new_i;

   logic         valid_a, bd_a, valid_b, bd_b;
   logic [127:0] data_a, data_b;
   logic [31:0]  pc_a, pc_b;
   logic [4:0]   exc_a, exc_b;
   logic [1:0]   state_a, state_b;
`ifdef PIPE_STAGE_PERF_EN
   logic [15:0]  bubble_cnt_a, flush_cnt_a, bubble_cnt_b, flush_cnt_b;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.BUBBLE_KEEP_PC(1)) u_keep (
      .clk(clk), .reset(reset), .en(en), .stall(stall), .req(req),
      .valid_i(valid_i), .data_i(data_i), .pc_i(pc_i), .exc_i(exc_i),
      .exc_new_i(exc_new_i), .bd_i(bd_i),
      .valid_o(valid_a), .data_o(data_a), .pc_o(pc_a), .exc_o(exc_a),
      .bd_o(bd_a), .state_o(state_a)
`ifdef PIPE_STAGE_PERF_EN
      , .bubble_cnt_o(bubble_cnt_a), .flush_cnt_o(flush_cnt_a)
`endif
   );

   pipe_stage_reg #(.BUBBLE_KEEP_PC(0)) u_zero (
      .clk(clk), .reset(reset), .en(en), .stall(stall), .req(req),
      .valid_i(valid_i), .data_i(data_i), .pc_i(pc_i), .exc_i(exc_i),
      .exc_new_i(exc_new_i), .bd_i(bd_i),
      .valid_o(valid_b), .data_o(data_b), .pc_o(pc_b), .exc_o(exc_b),
      .bd_o(bd_b), .state_o(state_b)
`ifdef PIPE_STAGE_PERF_EN
      , .bubble_cnt_o(bubble_cnt_b), .flush_cnt_o(flush_cnt_b)
`endif
   );

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkKeep(input string tag, input logic v, input logic [127:0] d,
                            input logic [31:0] pc, input logic [4:0] exc,
                            input logic bd, input logic [1:0] st);
      checkOutput({tag, ".valid"}, valid_a, v);
      checkOutput({tag, ".data"},  data_a,  d);
      checkOutput({tag, ".pc"},    pc_a,    pc);
      checkOutput({tag, ".exc"},   exc_a,   exc);
      checkOutput({tag, ".bd"},    bd_a,    bd);
      checkOutput({tag, ".state"}, state_a, st);
   endtask

   task automatic applyStimulus(input logic r, input logic e, input logic s, input logic q,
                                input logic v, input logic [127:0] d, input logic [31:0] pc,
                                input logic [4:0] ex, input logic [4:0] exn, input logic bd);
      reset = r; en = e; stall = s; req = q; valid_i = v; data_i = d;
      pc_i = pc; exc_i = ex; exc_new_i = exn; bd_i = bd;
      @(posedge clk);
      #1;
   endtask

   localparam logic [127:0] D1 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
   localparam logic [127:0] D2 = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
   localparam logic [127:0] D3 = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
   localparam logic [127:0] D4 = 128'h5a5a_5a5a_a5a5_a5a5_3c3c_3c3c_c3c3_c3c3;
   localparam logic [127:0] D5 = 128'h1357_9bdf_2468_ace0_1111_2222_3333_4444;

   initial begin
      $display("[TB] start");

      applyStimulus(1, 0, 0, 0, 0, 128'h0, 32'h0, EXC_NONE, EXC_NONE, 0);
      checkKeep("reset", 0, 0, 32'h0, 0, 0, ST_RUN);
      checkOutput("reset.zero_state", state_b, ST_RUN);

      applyStimulus(0, 1, 0, 0, 1, D1, 32'h3004, EXC_NONE, EXC_INT, 0);
      checkKeep("run1", 1, D1, 32'h3004, 0, 0, ST_RUN);
      checkOutput("run1.zero_pc", pc_b, 32'h3004);

      applyStimulus(0, 1, 1, 0, 1, D2, 32'h3010, EXC_ADEL, EXC_OV, 1);
      checkKeep("bubble", 0, 0, 32'h3010, 0, 1, ST_BUBBLE);
      checkOutput("bubble.zero_pc", pc_b, 32'h0);
      checkOutput("bubble.zero_bd", bd_b, 1'b0);
      checkOutput("bubble.zero_state", state_b, ST_BUBBLE);

      applyStimulus(0, 0, 1, 1, 1, D2, 32'h3020, EXC_ADEL, EXC_OV, 1);
      checkKeep("flush_over_stall", 0, 0, 32'h4180, 0, 0, ST_FLUSH);
      checkOutput("flush.zero_pc", pc_b, 32'h4180);

      applyStimulus(0, 1, 0, 1, 1, D3, 32'h3030, EXC_NONE, EXC_NONE, 1);
      checkKeep("flush_again", 0, 0, 32'h4180, 0, 0, ST_FLUSH);

      applyStimulus(0, 1, 0, 0, 1, D3, 32'h3034, EXC_ADEL, EXC_OV, 0);
      checkKeep("merge_old_wins", 1, D3, 32'h3034, EXC_ADEL, 0, ST_RUN);

      applyStimulus(0, 1, 0, 0, 1, D2, 32'h3038, EXC_NONE, EXC_RI, 0);
      checkOutput("merge_new.exc", exc_a, EXC_RI);

      applyStimulus(0, 1, 0, 0, 0, D1, 32'h303c, EXC_ADEL, EXC_RI, 0);
      checkOutput("merge_invalid.exc", exc_a, 5'd0);
      checkOutput("merge_invalid.valid", valid_a, 1'b0);
      checkOutput("merge_invalid.data", data_a, D1);

      applyStimulus(0, 1, 0, 0, 1, D4, 32'h3040, EXC_NONE, EXC_ADES, 1);
      checkKeep("load", 1, D4, 32'h3040, EXC_ADES, 1, ST_RUN);

      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 0, 0, D5 ^ 128'(i), 32'h3100 + 32'(i), EXC_OV, EXC_RI, 0);
         checkKeep("hold", 1, D4, 32'h3040, EXC_ADES, 1, ST_HOLD);
      end

      applyStimulus(0, 1, 0, 0, 1, D5, 32'h3050, EXC_NONE, EXC_NONE, 0);
      checkKeep("resume", 1, D5, 32'h3050, 0, 0, ST_RUN);

      applyStimulus(0, 0, 1, 0, 1, D1, 32'h3060, EXC_ADEL, EXC_NONE, 0);
      checkKeep("bubble_en0", 0, 0, 32'h3060, 0, 0, ST_BUBBLE);

      applyStimulus(1, 1, 1, 1, 1, D1, 32'h3070, EXC_ADEL, EXC_NONE, 1);
      checkKeep("reset_override", 0, 0, 32'h0, 0, 0, ST_RUN);

`ifdef PIPE_STAGE_PERF_EN
      checkOutput("perf.reset_bubble", bubble_cnt_a, 16'd0);
      checkOutput("perf.reset_flush", flush_cnt_a, 16'd0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 1, D1, 32'h3080, EXC_NONE, EXC_NONE, 0);
      for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 1, 1, D1, 32'h3080, EXC_NONE, EXC_NONE, 0);
      applyStimulus(0, 1, 0, 0, 1, D2, 32'h3084, EXC_NONE, EXC_NONE, 0);
      checkOutput("perf.bubble3", bubble_cnt_a, 16'd3);
      checkOutput("perf.flush2", flush_cnt_a, 16'd2);
      checkOutput("perf.no_side_effect_pc", pc_a, 32'h3084);
      for (int i = 0; i < 65540; i++) applyStimulus(0, 1, 1, 0, 1, D1, 32'h3088, EXC_NONE, EXC_NONE, 0);
      checkOutput("perf.saturate", bubble_cnt_a, 16'hFFFF);
      checkOutput("perf.flush_unchanged", flush_cnt_a, 16'd2);
      applyStimulus(1, 0, 0, 0, 0, D1, 32'h0, EXC_NONE, EXC_NONE, 0);
      checkOutput("perf.clear_bubble", bubble_cnt_b, 16'd0);
      checkOutput("perf.clear_flush", flush_cnt_b, 16'd0);
      checkOutput("perf.clear_bubble_keep", bubble_cnt_a, 16'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
